ser_link_rx: RTL and testbench

Parametrised serial ingress unit for the ANN ASIC. It replaces the fixed single-bit, byte-wide deserializer in front of the MLP controller with a LANES-wide, DATA_W-bit framed receiver. Words are buffered in a first-word-fall-through FIFO behind a valid/ready handshake, with overflow and framing error reporting. It sits between the chip's serial input pins and the controller's incoming_data/incoming_data_valid path.

---
 rtl/ser_link_rx.sv | 156 +++++++++++++++
 tb/tb_ser_link_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ser_link_rx.sv
// Framed LANES-wide serial receiver feeding a first-word-fall-through word FIFO.
// Optional parity beat enabled by defining PARITY_EN.
`timescale 1ns/1ps
module ser_link_rx #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              ser_in,
  input  logic                          ser_en,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int BEATS = DATA_W / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

`ifdef PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err, r_parity_err;
  logic              w_push, w_frame_err_next, w_parity_err_next;
  logic              w_last, w_par_bad;

  assign w_last = (r_cnt == CW'(BEATS - 1));

`ifdef PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_push            = 1'b0;
    w_frame_err_next  = 1'b0;
    w_parity_err_next = 1'b0;
    if (ser_en) begin
      case (r_state)
        S_IDLE: if (!ser_in[0]) w_state_next = S_DATA;
        S_DATA: begin
          if (w_last) begin
`ifdef PARITY_EN
            w_state_next = S_PAR;
`else
            w_state_next = S_STOP;
`endif
          end
        end
`ifdef PARITY_EN
        S_PAR:  w_state_next = S_STOP;
`endif
        S_STOP: begin
          // Stop symbol and parity are judged independently; either one drops the word.
          w_state_next      = S_IDLE;
          w_frame_err_next  = !ser_in[0];
          w_parity_err_next = w_par_bad;
          w_push            = ser_in[0] && !w_par_bad;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef PARITY_EN
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_frame_err  <= w_frame_err_next;
      r_parity_err <= w_parity_err_next;
      if (ser_en) begin
        if (r_state == S_IDLE) begin
          r_cnt <= '0;
`ifdef PARITY_EN
          r_par_bad <= 1'b0;
`endif
        end
        if (r_state == S_DATA) begin
          r_shift[r_cnt*LANES +: LANES] <= ser_in;
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef PARITY_EN
        if (r_state == S_PAR) r_par_bad <= ser_in[0] ^ (^r_shift);
`endif
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              w_full, w_pop, w_wr, w_drop;

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = valid && ready;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)   r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  assign valid      = (r_count != '0);
  assign data_out   = valid ? r_mem[r_rptr] : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ser_link_rx.sv
// Directed bench for ser_link_rx: a 2-lane instance and a 1-lane instance, hand-computed expectations.
`timescale 1ns/1ps
module tb_ser_link_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ser_a;
  logic       en_a, ready_a;
  logic [7:0] data_a;
  logic [2:0] count_a;
  logic       valid_a, busy_a, ovf_a, ferr_a, perr_a;
  logic [0:0] ser_b;
  logic       en_b, ready_b;
  logic [7:0] data_b;
  logic [2:0] count_b;
  logic       valid_b, busy_b, ovf_b, ferr_b, perr_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ser_link_rx #(.DATA_W(8), .LANES(2), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .ser_in(ser_a), .ser_en(en_a), .data_out(data_a),
    .valid(valid_a), .ready(ready_a), .fifo_count(count_a), .busy(busy_a),
    .overflow(ovf_a), .frame_err(ferr_a), .parity_err(perr_a)
  );

  ser_link_rx #(.DATA_W(8), .LANES(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .ser_in(ser_b), .ser_en(en_b), .data_out(data_b),
    .valid(valid_b), .ready(ready_b), .fifo_count(count_b), .busy(busy_b),
    .overflow(ovf_b), .frame_err(ferr_b), .parity_err(perr_b)
  );

  task automatic beat_b(input logic b, input logic rdy);
    @(negedge clk);
    ser_b = b; en_b = 1'b1; ready_b = rdy;
  endtask

  task automatic send_b(input logic [7:0] w, input logic stop_bit, input logic par_bit, input logic rdy_stop);
    $display("frame_b word=%h stop=%0b par=%0b ready_on_stop=%0b", w, stop_bit, par_bit, rdy_stop);
    beat_b(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) beat_b(w[i], 1'b0);
`ifdef PARITY_EN
    beat_b(par_bit, 1'b0);
`endif
    beat_b(stop_bit, rdy_stop);
  endtask

  task automatic idle_b;
    @(negedge clk);
    en_b = 1'b0; ser_b = 1'b1; ready_b = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ser_a = 2'b01; en_a = 1'b0; ready_a = 1'b0;
    ser_b = 1'b1; en_b = 1'b0; ready_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_b); end
    n_cmp++; if (data_b !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_b); end
    n_cmp++; if (count_b !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_b); end
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_b); end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", ovf_b); end
    n_cmp++; if (ferr_b !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", ferr_b); end
    n_cmp++; if (perr_b !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b want 0", perr_b); end
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
  endtask

  task automatic test_lanes2;
    logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    $display("frame_a word=a5 lanes=2");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ser_a = seq[i]; en_a = 1'b1;
    end
`ifdef PARITY_EN
    @(negedge clk); ser_a = 2'b10;
`endif
    @(negedge clk); ser_a = 2'b11;
    @(negedge clk); en_a = 1'b0; ser_a = 2'b01;
    n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL lanes2_valid: got %b want 1", valid_a); end
    n_cmp++; if (data_a !== 8'hA5) begin n_bad++; $display("FAIL lanes2_data: got %h want a5", data_a); end
    n_cmp++; if (count_a !== 3'd1) begin n_bad++; $display("FAIL lanes2_count: got %0d want 1", count_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL lanes2_busy: got %b want 0", busy_a); end
    ready_a = 1'b1;
    @(negedge clk); ready_a = 1'b0;
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL lanes2_pop_valid: got %b want 0", valid_a); end
    n_cmp++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL lanes2_pop_data: got %h want 00", data_a); end
  endtask

  task automatic test_stretch;
    logic [10:0] bits;
    int nbeats;
    int busy_cnt = 0;
`ifdef PARITY_EN
    bits = {1'b1, 1'b0, 8'h3C, 1'b0};
    nbeats = 11;
`else
    bits = {1'b0, 1'b1, 8'h3C, 1'b0};
    nbeats = 10;
`endif
    $display("frame_b word=3c stretched beats=%0d", nbeats);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk); if (busy_b) busy_cnt++;
      ser_b = bits[k]; en_b = 1'b1;
      @(negedge clk); if (busy_b) busy_cnt++;
      en_b = 1'b0;
    end
    @(negedge clk); if (busy_b) busy_cnt++;
    ser_b = 1'b1;
    n_cmp++; if (busy_cnt != 2*(nbeats-1)) begin n_bad++; $display("FAIL stretch_busy_cycles: got %0d want %0d", busy_cnt, 2*(nbeats-1)); end
    n_cmp++; if (valid_b !== 1'b1) begin n_bad++; $display("FAIL stretch_valid: got %b want 1", valid_b); end
    n_cmp++; if (data_b !== 8'h3C) begin n_bad++; $display("FAIL stretch_data: got %h want 3c", data_b); end
    ready_b = 1'b1;
    @(negedge clk); ready_b = 1'b0;
    n_cmp++; if (count_b !== 3'd0) begin n_bad++; $display("FAIL stretch_pop_count: got %0d want 0", count_b); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_q [4] = '{8'h12, 8'h13, 8'h14, 8'h66};
    for (int i = 0; i < 4; i++) send_b(8'h11 + 8'(i), 1'b1, ^(8'h11 + 8'(i)), 1'b0);
    send_b(8'h66, 1'b1, ^8'h66, 1'b1);
    idle_b();
    n_cmp++; if (count_b !== 3'd4) begin n_bad++; $display("FAIL fullpush_count: got %0d want 4", count_b); end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL fullpush_overflow: got %b want 0", ovf_b); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (data_b !== exp_q[i]) begin n_bad++; $display("FAIL fullpush_drain%0d: got %h want %h", i, data_b, exp_q[i]); end
      ready_b = 1'b1;
      @(negedge clk);
    end
    ready_b = 1'b0;
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL fullpush_empty: got %b want 0", valid_b); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) send_b(8'(i), 1'b1, ^8'(i), 1'b0);
    idle_b();
    n_cmp++; if (count_b !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", count_b); end
    n_cmp++; if (ovf_b !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf_b); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (data_b !== 8'(i)) begin n_bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, data_b, 8'(i)); end
      ready_b = 1'b1;
      @(negedge clk);
    end
    ready_b = 1'b0;
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL ovf_lost_word: valid got %b want 0", valid_b); end
    n_cmp++; if (ovf_b !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_b); end
  endtask

  task automatic test_frame_err;
    send_b(8'h55, 1'b0, ^8'h55, 1'b0);
    idle_b();
    n_cmp++; if (ferr_b !== 1'b1) begin n_bad++; $display("FAIL ferr_pulse: got %b want 1", ferr_b); end
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL ferr_no_push: got %b want 0", valid_b); end
    n_cmp++; if (perr_b !== 1'b0) begin n_bad++; $display("FAIL ferr_perr: got %b want 0", perr_b); end
    @(negedge clk);
    n_cmp++; if (ferr_b !== 1'b0) begin n_bad++; $display("FAIL ferr_one_cycle: got %b want 0", ferr_b); end
    send_b(8'h7E, 1'b1, ^8'h7E, 1'b0);
    idle_b();
    n_cmp++; if (data_b !== 8'h7E) begin n_bad++; $display("FAIL ferr_recover_data: got %h want 7e", data_b); end
    n_cmp++; if (ferr_b !== 1'b0) begin n_bad++; $display("FAIL ferr_recover_flag: got %b want 0", ferr_b); end
    ready_b = 1'b1;
    @(negedge clk); ready_b = 1'b0;
  endtask

`ifdef PARITY_EN
  task automatic test_parity;
    send_b(8'h07, 1'b1, 1'b0, 1'b0);
    idle_b();
    n_cmp++; if (perr_b !== 1'b1) begin n_bad++; $display("FAIL par_pulse: got %b want 1", perr_b); end
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL par_no_push: got %b want 0", valid_b); end
    n_cmp++; if (ferr_b !== 1'b0) begin n_bad++; $display("FAIL par_ferr: got %b want 0", ferr_b); end
    @(negedge clk);
    n_cmp++; if (perr_b !== 1'b0) begin n_bad++; $display("FAIL par_one_cycle: got %b want 0", perr_b); end
    send_b(8'h07, 1'b1, 1'b1, 1'b0);
    idle_b();
    n_cmp++; if (data_b !== 8'h07) begin n_bad++; $display("FAIL par_good_data: got %h want 07", data_b); end
    n_cmp++; if (perr_b !== 1'b0) begin n_bad++; $display("FAIL par_good_flag: got %b want 0", perr_b); end
    ready_b = 1'b1;
    @(negedge clk); ready_b = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    send_b(8'h42, 1'b1, ^8'h42, 1'b0);
    $display("frame_b partial then reset");
    beat_b(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) beat_b(1'b1, 1'b0);
    @(negedge clk); reset = 1'b1; en_b = 1'b0; ser_b = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_b); end
    n_cmp++; if (count_b !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", count_b); end
    n_cmp++; if (data_b !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", data_b); end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow: got %b want 0", ovf_b); end
    send_b(8'h99, 1'b1, ^8'h99, 1'b0);
    idle_b();
    n_cmp++; if (data_b !== 8'h99) begin n_bad++; $display("FAIL rstmid_next_data: got %h want 99", data_b); end
    n_cmp++; if (count_b !== 3'd1) begin n_bad++; $display("FAIL rstmid_next_count: got %0d want 1", count_b); end
  endtask

  initial begin
    test_reset();
    test_lanes2();
    test_stretch();
    test_full_push_pop();
    test_overflow();
    test_frame_err();
`ifdef PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
